// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Size codes match the MemRead/MemWrite encoding from the MIPS control unit.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // Wide enough for the largest supported wait-state count (15).
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
// Write side turns a size/lane/data triple into byte enables and a replicated
// write word; read side picks the addressed lane out of a stored word and
// sign- or zero-extends it. Low address bits beyond the access size are
// ignored here, which gives the masking behaviour when alignment checking
// is not built in.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_t       size_wr,
  input  size_t       size_rd,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Write path: replicate the store data across lanes, enable only the target lanes.
  always_comb begin
    byte_en = 4'b0000;
    wr_word = 32'h0;
    case (size_wr)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wr_word = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        byte_en = 4'b1111;
        wr_word = wdata;
      end
      default: begin
        byte_en = 4'b0000;
        wr_word = 32'h0;
      end
    endcase
  end

  // Read path: select the addressed lane and extend it to 32 bits.
  always_comb begin
    rd_byte = 8'h0;
    rd_half = 16'h0;
    rd_data = 32'h0;
    case (lane)
      2'b00:   rd_byte = mem_word[7:0];
      2'b01:   rd_byte = mem_word[15:8];
      2'b10:   rd_byte = mem_word[23:16];
      default: rd_byte = mem_word[31:24];
    endcase
    rd_half = lane[1] ? mem_word[31:16] : mem_word[15:0];
    case (size_rd)
      SZ_BYTE: rd_data = {{24{~is_unsigned & rd_byte[7]}}, rd_byte};
      SZ_HALF: rd_data = {{16{~is_unsigned & rd_half[15]}}, rd_half};
      SZ_WORD: rd_data = mem_word;
      default: rd_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data memory with configurable wait states.
// One request in flight; the access happens on the edge entering RESP.
// Optional build macro DMEM_ALIGN_CHECK_EN turns misaligned halfword/word
// accesses into errors; without it the low address bits are masked.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_read,
  input  logic [1:0]  req_write,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
    WAIT_CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t                state, next_state;
  logic [WAIT_CNT_W-1:0] wait_cnt, next_cnt;
  logic                  accept, enter_resp;

  logic [31:0] addr_q, wdata_q;
  size_t       read_q, write_q;
  logic        unsigned_q;

  logic [31:0] cur_addr, cur_wdata;
  size_t       cur_read, cur_write;
  logic        cur_unsigned;
  logic        req_err;

  logic [IDX_W-1:0] word_idx;
  logic [31:0]      mem_word, wr_word, ld_data;
  logic [3:0]       byte_en;

  logic [31:0] mem [DEPTH_WORDS];

  // State and wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          next_cnt = '0;
          if (WAIT_CYCLES == 0) begin
            next_state = S_RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          next_state = S_RESP;
          enter_resp = 1'b1;
          next_cnt   = '0;
        end else begin
          next_cnt = wait_cnt + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Capture the whole request at accept so later req_* changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      read_q     <= SZ_NONE;
      write_q    <= SZ_NONE;
      unsigned_q <= 1'b0;
    end else if (accept) begin
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      read_q     <= size_t'(req_read);
      write_q    <= size_t'(req_write);
      unsigned_q <= req_unsigned;
    end
  end

  // With zero wait states the access happens on the accept edge, so the
  // live request is used while idle; otherwise the captured copy is used.
  always_comb begin
    cur_addr     = (state == S_IDLE) ? req_addr : addr_q;
    cur_wdata    = (state == S_IDLE) ? req_wdata : wdata_q;
    cur_read     = (state == S_IDLE) ? size_t'(req_read) : read_q;
    cur_write    = (state == S_IDLE) ? size_t'(req_write) : write_q;
    cur_unsigned = (state == S_IDLE) ? req_unsigned : unsigned_q;
  end

  // Request rejection: simultaneous load/store, out-of-range, optional misalignment.
  always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
    size_t acc_size;
    acc_size = (cur_read != SZ_NONE) ? cur_read : cur_write;
`endif
    req_err = ((cur_read != SZ_NONE) && (cur_write != SZ_NONE)) ||
              (|cur_addr[31:IDX_W+2]);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((acc_size == SZ_HALF) && cur_addr[0]) req_err = 1'b1;
    if ((acc_size == SZ_WORD) && (cur_addr[1:0] != 2'b00)) req_err = 1'b1;
`endif
  end

  assign word_idx = cur_addr[IDX_W+1:2];
  assign mem_word = mem[word_idx];

  dmem_lane_align u_lane_align (
    .size_wr     (cur_write),
    .size_rd     (cur_read),
    .lane        (cur_addr[1:0]),
    .is_unsigned (cur_unsigned),
    .wdata       (cur_wdata),
    .mem_word    (mem_word),
    .byte_en     (byte_en),
    .wr_word     (wr_word),
    .rd_data     (ld_data)
  );

  // Store commit on the edge entering RESP; reset drops an uncommitted store.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  // Response data/error: loaded entering RESP, held through RESP, cleared on exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= req_err;
      rsp_rdata <= req_err ? 32'h0 : ld_data;
    end else if ((state == S_RESP) && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
// (WAIT_CYCLES=2, DEPTH_WORDS=256). Honours DMEM_ALIGN_CHECK_EN for the
// misaligned word-load expectation.
module tb_dmem_responder;

  localparam int WAIT_CYCLES = 2;
  localparam int LATENCY     = WAIT_CYCLES + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_read;
  logic [1:0]  req_write;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int passes = 0;

  dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Issue one request, check latency and response, optionally stall rsp_ready.
  task automatic applyStimulus(input string tag, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] rd,
                               input logic [1:0] wr, input logic uns,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int hold);
    int lat;
    @(negedge clk);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_wdata    = wdata;
    req_read     = rd;
    req_write    = wr;
    req_unsigned = uns;
    lat = 0;
    while (!req_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'h5A5A_5A5A;
    req_read     = 2'b11;
    req_write    = 2'b11;
    req_unsigned = ~uns;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(LATENCY));
    if (!rsp_valid) return;
    checkOutput({tag, " rdata"}, rsp_rdata, exp_rdata);
    checkOutput({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    checkOutput({tag, " ready low"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, " hold rdata"}, rsp_rdata, exp_rdata);
      checkOutput({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, " valid drop"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, " rdata clr"}, rsp_rdata, 32'h0);
    checkOutput({tag, " err clr"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, " ready back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_read     = 2'b00;
    req_write    = 2'b00;
    req_unsigned = 1'b0;
    rsp_ready    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst rsp_err", 32'(rsp_err), 32'd0);

    $display("[TB] stores and loads");
    applyStimulus("sw 0x0", 32'h0, 32'h1122_3344, 2'b00, 2'b11, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus("sw 0x10", 32'h10, 32'hDEAD_BEEF, 2'b00, 2'b11, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus("lw 0x10", 32'h10, 32'h0, 2'b11, 2'b00, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);
    applyStimulus("lb 0x13", 32'h13, 32'h0, 2'b01, 2'b00, 1'b0, 32'hFFFF_FFDE, 1'b0, 0);
    applyStimulus("lbu 0x13", 32'h13, 32'h0, 2'b01, 2'b00, 1'b1, 32'h0000_00DE, 1'b0, 0);
    applyStimulus("lh 0x10", 32'h10, 32'h0, 2'b10, 2'b00, 1'b0, 32'hFFFF_BEEF, 1'b0, 0);
    applyStimulus("lhu 0x12", 32'h12, 32'h0, 2'b10, 2'b00, 1'b1, 32'h0000_DEAD, 1'b0, 0);
    applyStimulus("lb 0x10", 32'h10, 32'h0, 2'b01, 2'b00, 1'b0, 32'hFFFF_FFEF, 1'b0, 0);
    applyStimulus("sb 0x11", 32'h11, 32'h0000_00AB, 2'b00, 2'b01, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus("lw after sb", 32'h10, 32'h0, 2'b11, 2'b00, 1'b0, 32'hDEAD_ABEF, 1'b0, 0);

    $display("[TB] error cases");
`ifdef DMEM_ALIGN_CHECK_EN
    applyStimulus("lw 0x2", 32'h2, 32'h0, 2'b11, 2'b00, 1'b0, 32'h0, 1'b1, 0);
`else
    applyStimulus("lw 0x2", 32'h2, 32'h0, 2'b11, 2'b00, 1'b0, 32'h1122_3344, 1'b0, 0);
`endif
    applyStimulus("lw 0x400", 32'h400, 32'h0, 2'b11, 2'b00, 1'b0, 32'h0, 1'b1, 0);
    applyStimulus("sw 0x410", 32'h410, 32'h0BAD_0BAD, 2'b00, 2'b11, 1'b0, 32'h0, 1'b1, 0);
    applyStimulus("rd+wr", 32'h10, 32'h0000_0000, 2'b11, 2'b11, 1'b0, 32'h0, 1'b1, 0);
    applyStimulus("lw keep", 32'h10, 32'h0, 2'b11, 2'b00, 1'b0, 32'hDEAD_ABEF, 1'b0, 0);
    applyStimulus("no-op", 32'h10, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus("lw 0x0", 32'h0, 32'h0, 2'b11, 2'b00, 1'b0, 32'h1122_3344, 1'b0, 0);

    $display("[TB] response stall");
    applyStimulus("lw hold", 32'h10, 32'h0, 2'b11, 2'b00, 1'b0, 32'hDEAD_ABEF, 1'b0, 5);

    $display("[TB] reset during wait");
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h1234_5678;
    req_read  = 2'b00;
    req_write = 2'b11;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 2'b00;
    checkOutput("abort in wait", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("abort no rsp", 32'(rsp_valid), 32'd0);
    end
    checkOutput("abort ready", 32'(req_ready), 32'd1);
    applyStimulus("lw after abort", 32'h10, 32'h0, 2'b11, 2'b00, 1'b0, 32'hDEAD_ABEF, 1'b0, 0);

    $display("[TB] halfword store");
    applyStimulus("sh 0x12", 32'h12, 32'h0000_CAFE, 2'b00, 2'b10, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus("lw after sh", 32'h10, 32'h0, 2'b11, 2'b00, 1'b0, 32'hCAFE_ABEF, 1'b0, 0);
    applyStimulus("lh 0x12", 32'h12, 32'h0, 2'b10, 2'b00, 1'b0, 32'hFFFF_CAFE, 1'b0, 0);
    applyStimulus("lbu 0x12", 32'h12, 32'h0, 2'b01, 2'b00, 1'b1, 32'h0000_00FE, 1'b0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS datapath: the memory-side end of the load/store interface driven by the CPU's ALU result, store data and 2-bit MemRead/MemWrite size controls. It accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, and performs the access on an internal word array. For a load it returns sized, extended read data. It replaces the zero-latency data memory and lets the pipelined datapath be exercised against a stalling memory.

## Interface
- DEPTH_WORDS, 256: word count of the internal array; power of two, ≥4.
- WAIT_CYCLES, 2: wait states between accept and response; 0..15.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder idle and able to accept.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or low halfword is used for sub-word stores.
- req_read  in  2  load size: 00 none, 01 byte, 10 halfword, 11 word.
- req_write  in  2  store size, same encoding.
- req_unsigned  in  1  zero-extend sub-word loads (lbu/lhu).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester consumes the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  the request was rejected; no memory side effect.

## Operation
- The FSM has three states.
  - IDLE: req_ready=1. Accept on req_valid&&req_ready.
  - WAIT: counts WAIT_CYCLES cycles.
  - RESP: rsp_valid=1; stays until rsp_ready.
- Transitions:
  - IDLE→WAIT on accept, or IDLE→RESP if WAIT_CYCLES=0.
  - WAIT→RESP when the counter reaches WAIT_CYCLES-1.
  - RESP→IDLE on rsp_ready.
- All request fields are registered at accept. Later changes on req_* are ignored until the next accept.
- A request with req_read=00 and req_write=00 is still accepted. It returns rsp_err=0 and rsp_rdata=0.
- Error conditions (rsp_err=1, no write):
  - req_read and req_write both nonzero;
  - address bits above the array index are nonzero, i.e. out of range.
- Byte order is little-endian. Word index = addr[log2(DEPTH_WORDS)+1:2]. Byte lane = addr[1:0]; halfword lane = addr[1].
- A store writes only the selected lanes. A byte store to 0x6 with wdata 0x000000AB sets bits [23:16] of word 1 to 0xAB.
- Loads extract the addressed lane:
  - sign-extended unless req_unsigned;
  - word loads are returned unchanged.
- Memory contents are not affected by reset; simulation initial value is all zeros.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE, wait counter 0.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge. With WAIT_CYCLES=0 it is high in the cycle after accept.
- A store commits on the edge entering RESP. A load samples the array on the same edge, so a load issued after a store returns the new data.
- rsp_rdata and rsp_err are stable for the whole RESP period. They return to 0 on the edge leaving RESP.
- After a response is consumed, req_ready is high again in the next cycle. Minimum request spacing is WAIT_CYCLES+2 cycles.
- req_ready and rsp_valid are never high together.
- Reset asserted mid-transaction aborts it. A store that has not yet reached its commit edge is dropped, and no response is produced.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - halfword access with addr[0]=1, or word access with addr[1:0]≠0, returns rsp_err=1;
  - no write, rsp_rdata=0.
- DMEM_ALIGN_CHECK_EN undefined:
  - low address bits are masked to the access size (halfword clears bit 0, word clears bits 1:0);
  - the access proceeds without error.

## Structure
- dmem_pkg holds:
  - size codes SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state encoding S_IDLE/S_WAIT/S_RESP;
  - width of the wait counter.
- Sub-module dmem_lane_align (combinational) contains:
  - write path: from size, addr[1:0] and wdata, produces a 4-bit byte-enable and the lane-shifted write word;
  - read path: from the stored word, size, lane and req_unsigned, produces the extended read data.
- The FSM, counter, request registers and array live in dmem_responder.

## Test plan
- Reset, then idle: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 (WAIT_CYCLES=2): rsp_valid rises 3 edges after each accept; load returns 0xDEADBEEF.
- With word 0x10 = 0xDEADBEEF:
  - byte load 0x13 → 0xFFFFFFDE;
  - unsigned byte load 0x13 → 0x000000DE;
  - halfword load 0x10 → 0xFFFFBEEF.
- Byte store 0xAB to 0x11, then word load 0x10 → 0xDEADABEF.
- Error cases:
  - word load from 0x2 with DMEM_ALIGN_CHECK_EN → rsp_err=1, rsp_rdata=0; without the macro → data of word 0;
  - address 0x400 with DEPTH_WORDS=256 → rsp_err=1;
  - req_read=11 with req_write=11 → rsp_err=1, memory unchanged.
- Handshake and reset:
  - hold rsp_ready=0 for 5 cycles → response held stable and req_ready stays 0;
  - assert reset during WAIT of a store → no response, and a later load of that address returns the old value.
